// File: rtl/seq_divider.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Produces one quotient bit per clock. Divide-by-zero and quotient overflow complete in a single cycle.
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Dividend,
    input  logic [7:0]  Divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  Quotient,
    output logic [7:0]  Remainder,
    output logic        div_zero,
    output logic        overflow
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] r_q, r_d;   // R[8] is always 0 between steps, so only 8 bits are kept
    logic [7:0] s_q, s_d;
    logic [7:0] dv_q, dv_d;
    logic       ezero_q, ezero_d, eovf_q, eovf_d;
    logic       done_q, done_d;
    logic [7:0] quot_q, quot_d, rem_q, rem_d;
    logic       dzo_q, dzo_d, ovo_q, ovo_d;

    logic [8:0] t;
    logic       ge;
    logic [7:0] r_step, s_step;

    always_comb begin
        t      = {r_q, s_q[7]};
        ge     = t >= {1'b0, dv_q};
        r_step = ge ? 8'(t - {1'b0, dv_q}) : t[7:0];
        s_step = {s_q[6:0], ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        s_d     = s_q;
        dv_d    = dv_q;
        ezero_d = ezero_q;
        eovf_d  = eovf_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;
        ovo_d   = ovo_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CALC;
                cnt_d   = 3'd0;
                r_d     = Dividend[15:8];
                s_d     = Dividend[7:0];
                dv_d    = Divisor;
                ezero_d = (Divisor == 8'd0);
                eovf_d  = (Divisor != 8'd0) && (Dividend[15:8] >= Divisor);
            end
            CALC: if (ezero_q || eovf_q) begin
                // Error operations skip the iterations and report at once.
                state_d = IDLE;
                done_d  = 1'b1;
                quot_d  = 8'hFF;
                rem_d   = ezero_q ? s_q : 8'hFF;
                dzo_d   = ezero_q;
                ovo_d   = eovf_q;
            end else begin
                r_d   = r_step;
                s_d   = s_step;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    quot_d  = s_step;
                    rem_d   = r_step;
                    dzo_d   = 1'b0;
                    ovo_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            r_q     <= 8'd0;
            s_q     <= 8'd0;
            dv_q    <= 8'd0;
            ezero_q <= 1'b0;
            eovf_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= 8'd0;
            rem_q   <= 8'd0;
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            s_q     <= s_d;
            dv_q    <= dv_d;
            ezero_q <= ezero_d;
            eovf_q  <= eovf_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
            ovo_q   <= ovo_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign div_zero  = dzo_q;
    assign overflow  = ovo_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, back-to-back and reset-abort sequences, random sweep vs arithmetic model.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] Dividend = 16'd0;
    logic [7:0]  Divisor = 8'd0;
    logic        busy, done, div_zero, overflow;
    logic [7:0]  Quotient, Remainder;

    int checks = 0;
    int errors = 0;

    seq_divider dut (
        .clk(clk), .rst(rst), .start(start), .Dividend(Dividend), .Divisor(Divisor),
        .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder),
        .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer division with the error rules.
    function automatic vec_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        vec_t v;
        int   qi;
        v.dvd = dvd; v.dvs = dvs;
        if (dvs == 0) begin
            v.q = 8'hFF; v.r = dvd[7:0]; v.dz = 1'b1; v.ov = 1'b0; v.lat = 1;
        end else begin
            qi = int'(dvd) / int'(dvs);
            if (qi > 255) begin
                v.q = 8'hFF; v.r = 8'hFF; v.dz = 1'b0; v.ov = 1'b1; v.lat = 1;
            end else begin
                v.q = 8'(qi); v.r = 8'(int'(dvd) % int'(dvs));
                v.dz = 1'b0; v.ov = 1'b0; v.lat = 8;
            end
        end
        return v;
    endfunction

    // Wait for done after an accepting edge; returns cycles from accept to done (-1 on timeout).
    task automatic wait_done(input string name, output int lat, output logic mid_change);
        logic [7:0] q0, r0;
        q0 = Quotient; r0 = Remainder;
        mid_change = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
            if (Quotient !== q0 || Remainder !== r0) mid_change = 1'b1;
        end
        if (lat < 0) chk({name, " timeout"}, 0, 1);
    endtask

    task automatic run_op(input string name, input vec_t v);
        int   lat;
        logic mid;
        Dividend = v.dvd; Divisor = v.dvs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        Dividend = 16'($urandom); Divisor = 8'($urandom);
        chk({name, " busy"}, int'(busy), 1);
        if (v.lat == 1) begin
            lat = 0; mid = 1'b0;
            if (done) lat = 0;
            @(posedge clk); #1;
            if (done) lat = 1; else chk({name, " timeout"}, 0, 1);
        end else begin
            wait_done(name, lat, mid);
            chk({name, " midchange"}, int'(mid), 0);
        end
        chk({name, " latency"}, lat, v.lat);
        chk({name, " Q"}, int'(Quotient), int'(v.q));
        chk({name, " R"}, int'(Remainder), int'(v.r));
        chk({name, " dz"}, int'(div_zero), int'(v.dz));
        chk({name, " ov"}, int'(overflow), int'(v.ov));
        chk({name, " busy_end"}, int'(busy), 0);
        @(posedge clk); #1;
        chk({name, " done_clr"}, int'(done), 0);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   lat;
        logic mid;
        logic sawdone;

        tbl[0] = '{16'd1000,  8'd7,   8'd142,  8'd6,   1'b0, 1'b0, 8};
        tbl[1] = '{16'hFEFF,  8'hFF,  8'hFF,   8'hFE,  1'b0, 1'b0, 8};
        tbl[2] = '{16'hFFFF,  8'hFF,  8'hFF,   8'hFF,  1'b0, 1'b1, 1};
        tbl[3] = '{16'h1234,  8'd0,   8'hFF,   8'h34,  1'b1, 1'b0, 1};
        tbl[4] = '{16'd100,   8'd10,  8'd10,   8'd0,   1'b0, 1'b0, 8};
        tbl[5] = '{16'd255,   8'd16,  8'd15,   8'd15,  1'b0, 1'b0, 8};
        tbl[6] = '{16'd0,     8'd1,   8'd0,    8'd0,   1'b0, 1'b0, 8};
        tbl[7] = '{16'h00FF,  8'd1,   8'hFF,   8'd0,   1'b0, 1'b0, 8};
        tbl[8] = '{16'h0100,  8'd1,   8'hFF,   8'hFF,  1'b0, 1'b1, 1};
        tbl[9] = '{16'h0FFF,  8'h10,  8'hFF,   8'h0F,  1'b0, 1'b0, 8};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset Q", int'(Quotient), 0);
        chk("reset R", int'(Remainder), 0);
        chk("reset dz", int'(div_zero), 0);
        chk("reset ov", int'(overflow), 0);

        for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        // Start held high: 100/10, then 255/16 accepted in the done cycle.
        Dividend = 16'd100; Divisor = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        Dividend = 16'd200; Divisor = 8'd3;
        wait_done("b2b first", lat, mid);
        chk("b2b first latency", lat, 8);
        chk("b2b first Q", int'(Quotient), 10);
        chk("b2b first R", int'(Remainder), 0);
        Dividend = 16'd255; Divisor = 8'd16;
        @(posedge clk); #1;
        chk("b2b accept busy", int'(busy), 1);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c % 2 == 1) begin start = 1'b1; Dividend = 16'd7; Divisor = 8'd2; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        start = 1'b0;
        chk("b2b second latency", lat, 8);
        chk("b2b second Q", int'(Quotient), 15);
        chk("b2b second R", int'(Remainder), 15);
        @(posedge clk); #1;
        chk("b2b ignored start", int'(busy), 0);
        repeat (2) @(posedge clk); #1;

        // Reset during CALC aborts without done.
        Dividend = 16'd1000; Divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort Q", int'(Quotient), 0);
        chk("abort R", int'(Remainder), 0);
        @(posedge clk); #1 rst = 1'b0;
        sawdone = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done || busy) sawdone = 1'b1;
        end
        chk("abort no done", int'(sawdone), 0);
        run_op("after abort", tbl[0]);

        // Random sweep, biased so most operations take the iterative path.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0]  dvs;
            logic [15:0] dvd;
            int          mode;
            mode = int'($urandom_range(0, 7));
            dvs  = 8'($urandom);
            dvd  = 16'($urandom);
            if (mode == 0) dvs = 8'd0;
            else if (mode >= 2 && dvs != 0) dvd[15:8] = 8'($urandom_range(0, int'(dvs) - 1));
            v = model(dvd, dvs);
            run_op($sformatf("rnd%0d %0d/%0d", i, dvd, dvs), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
